// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: word width, rotater FSM states and step encoding,
// plus the single-step rotate used by the rotater datapath.
package pdp8_pkg;

  localparam int unsigned WORD_W = 12;
  localparam int unsigned HALF_W = WORD_W / 2;
  localparam int unsigned STEP_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } rot_state_e;

  typedef enum logic [1:0] {
    OpNone,
    OpLeft,
    OpRight,
    OpBsw
  } rot_op_e;

  // One rotate step on the 13-bit {L, AC} value.
  function automatic logic [WORD_W:0] rot_step(input rot_op_e op, input logic [WORD_W:0] v);
    case (op)
      OpLeft:  return {v[WORD_W-1:0], v[WORD_W]};
      OpRight: return {v[0], v[WORD_W], v[WORD_W-1:1]};
      OpBsw:   return {v[WORD_W], v[HALF_W-1:0], v[WORD_W-1:HALF_W]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/ck_edge.sv
// Registered rising-edge detector. The history flop resets high so a strobe
// already high when reset releases is not seen as an edge.
module ck_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ck,
  output logic rise
);

  logic last_ck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ck_q <= 1'b1;
    end else begin
      last_ck_q <= ck;
    end
  end

  assign rise = ck & ~last_ck_q;

endmodule

// File: rtl/rotater.sv
// PDP-8 link/accumulator rotater: RAL/RTL, RAR/RTR and optional BSW, one step
// per clock. Define ROTATER_BSW_EN to enable BSW (R_twice alone).
module rotater
  import pdp8_pkg::*;
(
  input  logic              clk,
  input  logic              CLEAR_n,
  input  logic              R_ck,
  input  logic              R_left,
  input  logic              R_right,
  input  logic              R_twice,
  input  logic [WORD_W-1:0] AC_in,
  input  logic              L_in,
  output logic [WORD_W-1:0] AC_out,
  output logic              L_out,
  output logic              L_force,
  output logic              busy,
  output logic              done
);

  logic ck_rise;

  ck_edge u_ck_edge (
    .clk   (clk),
    .rst_n (CLEAR_n),
    .ck    (R_ck),
    .rise  (ck_rise)
  );

  rot_state_e        state_q;
  rot_op_e           op_q, op_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [WORD_W:0]   rot_q, rot_next;
  logic [WORD_W-1:0] ac_out_q;
  logic              l_out_q, l_force_q, busy_q, done_q;

  // Opposing directions cancel to a pass-through.
  always_comb begin
    op_d    = OpNone;
    steps_d = '0;
    if (R_left && !R_right) begin
      op_d    = OpLeft;
      steps_d = R_twice ? STEP_W'(2) : STEP_W'(1);
    end else if (R_right && !R_left) begin
      op_d    = OpRight;
      steps_d = R_twice ? STEP_W'(2) : STEP_W'(1);
    end else if (!R_left && !R_right && R_twice) begin
`ifdef ROTATER_BSW_EN
      op_d    = OpBsw;
      steps_d = STEP_W'(1);
`else
      op_d    = OpNone;
      steps_d = '0;
`endif
    end
  end

  assign rot_next = rot_step(op_q, rot_q);

  always_ff @(posedge clk or negedge CLEAR_n) begin
    if (!CLEAR_n) begin
      state_q   <= StIdle;
      op_q      <= OpNone;
      steps_q   <= '0;
      rot_q     <= '0;
      ac_out_q  <= '0;
      l_out_q   <= 1'b0;
      l_force_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      l_force_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ck_rise) begin
            rot_q   <= {L_in, AC_in};
            op_q    <= op_d;
            steps_q <= steps_d;
            if (steps_d != '0) begin
              state_q <= StShift;
              busy_q  <= 1'b1;
            end else begin
              state_q   <= StDone;
              ac_out_q  <= AC_in;
              l_out_q   <= L_in;
              done_q    <= 1'b1;
              l_force_q <= 1'b1;
            end
          end
        end
        StShift: begin
          rot_q   <= rot_next;
          steps_q <= steps_q - STEP_W'(1);
          // Final step: publish the result together with done.
          if (steps_q == STEP_W'(1)) begin
            state_q   <= StDone;
            busy_q    <= 1'b0;
            ac_out_q  <= rot_next[WORD_W-1:0];
            l_out_q   <= rot_next[WORD_W];
            done_q    <= 1'b1;
            l_force_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign AC_out  = ac_out_q;
  assign L_out   = l_out_q;
  assign L_force = l_force_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
